// File: rtl/if_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls in, imem read port and IF/ID outputs.
// The stage itself takes the master side; the pipeline/bench takes the slave side.
interface if_stage_if;
  logic        StallF;
  logic        StallD;
  logic        PCSrcD;
  logic [31:0] PCBranchD;
  logic [31:0] ImemRdata;
  logic [31:0] ImemAddr;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic [31:0] InstrD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic [31:0] FetchCount;
  logic        PcFault;

  modport master (
    input  StallF, StallD, PCSrcD, PCBranchD, ImemRdata,
    output ImemAddr, PCF, PCPlus4F, InstrD, PCPlus4D, ValidD, FetchCount, PcFault
  );

  modport slave (
    output StallF, StallD, PCSrcD, PCBranchD, ImemRdata,
    input  ImemAddr, PCF, PCPlus4F, InstrD, PCPlus4D, ValidD, FetchCount, PcFault
  );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, imem address, IF/ID register,
// fetch counter and sticky out-of-range fetch flag.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 28
) (
  input logic         CLK,
  input logic         reset,
  if_stage_if.master  bus
);

  // 33 bits so a full 4 GiB memory depth still compares correctly
  localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_WORDS) << 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcPlus4;
    logic        valid;
  } ifId_t;

  localparam ifId_t IFID_BUBBLE = '{instr: 32'h0, pcPlus4: 32'h0, valid: 1'b0};

  logic [31:0] pcF, pcNext, pcPlus4F, instrF;
  logic [31:0] fetchCount, fetchCountNext;
  logic        pcFault, pcFaultNext;
  logic        inRange, loadD;
  ifId_t       ifId, ifIdNext;

  assign pcPlus4F = pcF + 32'd4;
  assign inRange  = {1'b0, pcF} < IMEM_LIMIT;
  // Out-of-range fetches read as NOP so garbage never reaches decode
  assign instrF   = inRange ? bus.ImemRdata : 32'h0000_0000;
  assign loadD    = !bus.StallD && !bus.PCSrcD;

  // Stall wins over redirect: the branch stays in D and is re-evaluated
  always_comb begin
    pcNext = pcPlus4F;
    if (bus.StallF)
      pcNext = pcF;
    else if (bus.PCSrcD)
      pcNext = {bus.PCBranchD[31:2], 2'b00};
  end

  always_comb begin
    ifIdNext       = ifId;
    fetchCountNext = fetchCount;
    pcFaultNext    = pcFault;
    if (bus.StallD) begin
      ifIdNext = ifId;
    end else if (bus.PCSrcD) begin
      ifIdNext = IFID_BUBBLE;
    end else begin
      ifIdNext.instr   = instrF;
      ifIdNext.pcPlus4 = pcPlus4F;
      ifIdNext.valid   = 1'b1;
    end
    if (loadD) begin
      fetchCountNext = fetchCount + 32'd1;
      pcFaultNext    = pcFault | ~inRange;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      pcF        <= RESET_PC;
      ifId       <= IFID_BUBBLE;
      fetchCount <= 32'h0;
      pcFault    <= 1'b0;
    end else begin
      pcF        <= pcNext;
      ifId       <= ifIdNext;
      fetchCount <= fetchCountNext;
      pcFault    <= pcFaultNext;
    end
  end

  assign bus.ImemAddr   = pcF;
  assign bus.PCF        = pcF;
  assign bus.PCPlus4F   = pcPlus4F;
  assign bus.InstrD     = ifId.instr;
  assign bus.PCPlus4D   = ifId.pcPlus4;
  assign bus.ValidD     = ifId.valid;
  assign bus.FetchCount = fetchCount;
  assign bus.PcFault    = pcFault;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run against a
// rule-level model of PC, IF/ID, fetch count and fault flag.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          IMEM_WORDS = 28;
  localparam logic [31:0] LIMIT = 32'(IMEM_WORDS * 4);

  logic CLK = 1'b0;
  logic reset = 1'b0;
  int   nVec = 0;
  int   nErr = 0;

  if_stage_if ifc ();
  if_stage #(.RESET_PC(RESET_PC), .IMEM_WORDS(IMEM_WORDS)) u_dut (
    .CLK(CLK), .reset(reset), .bus(ifc)
  );

  always #5 CLK = ~CLK;

  // 64-word backing store: words past IMEM_WORDS hold nonzero junk the DUT must mask
  logic [31:0] mem [0:63];
  assign ifc.ImemRdata = mem[ifc.ImemAddr[7:2]];

  // Reference state
  logic [31:0] mPC, mInstr, mPc4D, mCount;
  logic        mValid, mFault;

  function automatic logic [129:0] dutState();
    return {ifc.PCF, ifc.InstrD, ifc.PCPlus4D, ifc.ValidD, ifc.FetchCount, ifc.PcFault};
  endfunction

  function automatic logic [129:0] modelState();
    return {mPC, mInstr, mPc4D, mValid, mCount, mFault};
  endfunction

  task automatic fill_seq();
    for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 + 32'(i);
  endtask

  task automatic model_reset();
    mPC = RESET_PC; mInstr = 0; mPc4D = 0; mValid = 0; mCount = 0; mFault = 0;
  endtask

  // Apply one cycle of controls, advance the model by the stated rules, settle after the edge
  task automatic step(input logic sf, input logic sd, input logic src, input logic [31:0] tgt);
    logic [31:0] fetched;
    logic        inRange;
    ifc.StallF = sf; ifc.StallD = sd; ifc.PCSrcD = src; ifc.PCBranchD = tgt;
    inRange = (mPC < LIMIT);
    fetched = inRange ? mem[mPC[7:2]] : 32'h0;
    if (!sd) begin
      if (src) begin
        mInstr = 0; mPc4D = 0; mValid = 0;
      end else begin
        mInstr = fetched; mPc4D = mPC + 32'd4; mValid = 1'b1;
        mCount = mCount + 1;
        if (!inRange) mFault = 1'b1;
      end
    end
    if (!sf) mPC = src ? {tgt[31:2], 2'b00} : mPC + 32'd4;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    ifc.StallF = 0; ifc.StallD = 0; ifc.PCSrcD = 0; ifc.PCBranchD = 0;
    reset = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [129:0] exp;
    ifc.StallF = 0; ifc.StallD = 0; ifc.PCSrcD = 1; ifc.PCBranchD = 32'h40;
    reset = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    exp = {RESET_PC, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0};
    nVec++;
    if (dutState() !== exp) begin
      nErr++; $display("FAIL reset_state: got %h want %h", dutState(), exp);
    end
    nVec++;
    if ({ifc.ImemAddr, ifc.PCPlus4F} !== {RESET_PC, RESET_PC + 32'd4}) begin
      nErr++; $display("FAIL reset_addr: got %h/%h want %h/%h", ifc.ImemAddr, ifc.PCPlus4F, RESET_PC, RESET_PC + 32'd4);
    end
  endtask

  task automatic test_sequential();
    logic [129:0] exp;
    do_reset();
    repeat (3) step(0, 0, 0, 0);
    exp = {32'h0C, 32'h2000_0002, 32'h0C, 1'b1, 32'd3, 1'b0};
    nVec++;
    if (dutState() !== exp) begin
      nErr++; $display("FAIL seq_fetch: got %h want %h", dutState(), exp);
    end
    nVec++;
    if ({ifc.ImemAddr, ifc.PCPlus4F} !== {32'h0C, 32'h10}) begin
      nErr++; $display("FAIL seq_addr: got %h/%h want 0000000c/00000010", ifc.ImemAddr, ifc.PCPlus4F);
    end
  endtask

  task automatic test_stall();
    logic [129:0] exp;
    do_reset();
    repeat (2) step(0, 0, 0, 0);
    repeat (2) step(1, 1, 0, 0);
    exp = {32'h08, 32'h2000_0001, 32'h08, 1'b1, 32'd2, 1'b0};
    nVec++;
    if (dutState() !== exp) begin
      nErr++; $display("FAIL stall_hold: got %h want %h", dutState(), exp);
    end
    step(0, 0, 0, 0);
    exp = {32'h0C, 32'h2000_0002, 32'h0C, 1'b1, 32'd3, 1'b0};
    nVec++;
    if (dutState() !== exp) begin
      nErr++; $display("FAIL stall_release: got %h want %h", dutState(), exp);
    end
  endtask

  task automatic test_branch();
    logic [129:0] exp;
    do_reset();
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h43);
    exp = {32'h40, 32'h0, 32'h0, 1'b0, 32'd4, 1'b0};
    nVec++;
    if (dutState() !== exp) begin
      nErr++; $display("FAIL branch_flush: got %h want %h", dutState(), exp);
    end
    step(0, 0, 0, 0);
    exp = {32'h44, 32'h2000_0010, 32'h44, 1'b1, 32'd5, 1'b0};
    nVec++;
    if (dutState() !== exp) begin
      nErr++; $display("FAIL branch_target: got %h want %h", dutState(), exp);
    end
  endtask

  task automatic test_stall_vs_redirect();
    logic [129:0] exp;
    do_reset();
    repeat (4) step(0, 0, 0, 0);
    step(1, 1, 1, 32'h40);
    exp = {32'h10, 32'h2000_0003, 32'h10, 1'b1, 32'd4, 1'b0};
    nVec++;
    if (dutState() !== exp) begin
      nErr++; $display("FAIL stall_beats_branch: got %h want %h", dutState(), exp);
    end
    step(0, 0, 1, 32'h40);
    exp = {32'h40, 32'h0, 32'h0, 1'b0, 32'd4, 1'b0};
    nVec++;
    if (dutState() !== exp) begin
      nErr++; $display("FAIL branch_after_stall: got %h want %h", dutState(), exp);
    end
  endtask

  task automatic test_split_stalls();
    logic [129:0] exp;
    do_reset();
    repeat (2) step(0, 0, 0, 0);
    step(0, 1, 0, 0);  // PC moves, fetched word at 0x08 dropped
    exp = {32'h0C, 32'h2000_0001, 32'h08, 1'b1, 32'd2, 1'b0};
    nVec++;
    if (dutState() !== exp) begin
      nErr++; $display("FAIL stallD_only: got %h want %h", dutState(), exp);
    end
    step(1, 0, 0, 0);  // IF/ID reloads from held PC 0x0C
    exp = {32'h0C, 32'h2000_0003, 32'h10, 1'b1, 32'd3, 1'b0};
    nVec++;
    if (dutState() !== exp) begin
      nErr++; $display("FAIL stallF_only: got %h want %h", dutState(), exp);
    end
  endtask

  task automatic test_out_of_range();
    logic [129:0] exp;
    do_reset();
    repeat (28) step(0, 0, 0, 0);
    exp = {32'h70, 32'h2000_001B, 32'h70, 1'b1, 32'd28, 1'b0};
    nVec++;
    if (dutState() !== exp) begin
      nErr++; $display("FAIL oor_edge: got %h want %h", dutState(), exp);
    end
    step(0, 0, 0, 0);
    exp = {32'h74, 32'h0, 32'h74, 1'b1, 32'd29, 1'b1};
    nVec++;
    if (dutState() !== exp) begin
      nErr++; $display("FAIL oor_fetch: got %h want %h", dutState(), exp);
    end
    step(0, 0, 1, 32'h0);
    step(0, 0, 0, 0);
    exp = {32'h04, 32'h2000_0000, 32'h04, 1'b1, 32'd30, 1'b1};
    nVec++;
    if (dutState() !== exp) begin
      nErr++; $display("FAIL oor_sticky: got %h want %h", dutState(), exp);
    end
  endtask

  task automatic test_wrap();
    logic [129:0] exp;
    do_reset();
    step(0, 0, 1, 32'hFFFF_FFFF);
    nVec++;
    if ({ifc.PCF, ifc.PCPlus4F} !== {32'hFFFF_FFFC, 32'h0}) begin
      nErr++; $display("FAIL wrap_plus4: got %h/%h want fffffffc/00000000", ifc.PCF, ifc.PCPlus4F);
    end
    step(0, 0, 0, 0);
    exp = {32'h0, 32'h0, 32'h0, 1'b1, 32'd1, 1'b1};
    nVec++;
    if (dutState() !== exp) begin
      nErr++; $display("FAIL wrap_fetch: got %h want %h", dutState(), exp);
    end
  endtask

  task automatic test_async_reset();
    logic [129:0] exp;
    do_reset();
    repeat (5) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h100);
    step(0, 0, 0, 0);  // out-of-range fetch sets the fault
    @(posedge CLK);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    exp = {RESET_PC, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0};
    nVec++;
    if (dutState() !== exp) begin
      nErr++; $display("FAIL async_reset: got %h want %h", dutState(), exp);
    end
    @(negedge CLK);
    reset = 1'b1;
    step(0, 0, 0, 0);
    exp = {RESET_PC + 32'd4, 32'h2000_0000, RESET_PC + 32'd4, 1'b1, 32'd1, 1'b0};
    nVec++;
    if (dutState() !== exp) begin
      nErr++; $display("FAIL reset_resume: got %h want %h", dutState(), exp);
    end
  endtask

  task automatic test_random();
    logic        sf, sd, src;
    logic [31:0] tgt;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      sf  = ($urandom_range(0, 5) == 0);
      sd  = ($urandom_range(0, 5) == 0);
      src = ($urandom_range(0, 6) == 0);
      tgt = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
      step(sf, sd, src, tgt);
      nVec++;
      if ({dutState(), ifc.PCPlus4F, ifc.ImemAddr} !== {modelState(), mPC + 32'd4, mPC}) begin
        nErr++;
        $display("FAIL random_c%0d: got %h/%h/%h want %h/%h/%h", c, dutState(), ifc.PCPlus4F,
                 ifc.ImemAddr, modelState(), mPC + 32'd4, mPC);
      end
    end
  endtask

  initial begin
    fill_seq();
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_stall_vs_redirect();
    test_split_stalls();
    test_out_of_range();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
